multicycle_ctrl_hs: RTL and testbench

Parametrised successor to the team's multicycle CPU control FSM. It adds a memory ready/wait handshake on every memory state, a configurable memory timeout, and an illegal-opcode/timeout trap state with a trap-vector PC source. It sits between the instruction register opcode field and the datapath muxes/enables, and drives the same control bus as the existing controller.

---
 rtl/multicycle_ctrl_hs.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl_hs.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle CPU control FSM with memory ready/wait handshake, memory timeout and trap state.
// `define PERF_CNT_EN adds InstrCount/StallCount performance counters.
module multicycle_ctrl_hs #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic               mem_ready,
  output logic [3:0]         State,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic [1:0]         PCWriteCond,
  output logic               BranchSel,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               ReadDst,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               Trap,
  output logic [1:0]         TrapCause,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0]   InstrCount,
  output logic [CNT_W-1:0]   StallCount,
`endif
  output logic               Busy
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXEC, S_ALU_WB,
    S_BRANCH, S_JUMP, S_LI_ADDR, S_LI_RD, S_I_EXEC_SE, S_I_EXEC_ZE, S_TRAP, S_UNUSED
  } state_t;

  localparam logic [5:0] OP_LWI  = 6'b111011;
  localparam logic [5:0] OP_SWI  = 6'b111100;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_BNE  = 6'b100001;
  localparam logic [5:0] OP_J    = 6'b000001;
  localparam logic [5:0] OP_LI   = 6'b111001;
  localparam logic [5:0] OP_NOOP = 6'b000000;
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t               state, state_nxt;
  logic [1:0]           cause_nxt;
  logic                 imm_wb;
  logic                 is_mem, tmo, is_rtype;
  logic [ALUOP_W-1:0]   op_alu;

  assign State    = state;
  assign is_mem   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR) || (state == S_LI_RD);
  assign is_rtype = (Opcode[5:3] == 3'b010) && (Opcode[2:0] != 3'b110);
  assign op_alu   = ALUOP_W'(Opcode[2:0]);
  assign Busy     = Reset && is_mem && !mem_ready;

  // Counter only advances while a memory state is stalled, so it is already 0 on entry.
  generate
    if (MEM_TIMEOUT > 0) begin : g_tmo
      logic [WCNT_W-1:0] wait_cnt;
      assign tmo = is_mem && !mem_ready && (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1));
      always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)                        wait_cnt <= '0;
        else if (is_mem && !mem_ready && !tmo) wait_cnt <= wait_cnt + WCNT_W'(1);
        else                               wait_cnt <= '0;
      end
    end else begin : g_no_tmo
      assign tmo = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_FETCH;
      TrapCause <= 2'b00;
      imm_wb    <= 1'b0;
    end else begin
      state     <= state_nxt;
      TrapCause <= cause_nxt;
      imm_wb    <= (state == S_I_EXEC_SE) || (state == S_I_EXEC_ZE);
    end
  end

  always_comb begin
    state_nxt   = state;
    cause_nxt   = TrapCause;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = '0;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 2'b00;
    BranchSel   = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ReadDst     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    Trap        = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1; ALUSrcB = 2'b01; ALUOp = ALU_ADD; ReadDst = 1'b1;
        IRWrite = mem_ready; PCWrite = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10; ALUOp = ALU_ADD; ReadDst = is_rtype;
        if (Opcode == OP_LWI || Opcode == OP_SWI)            state_nxt = S_MEM_ADDR;
        else if (is_rtype)                                   state_nxt = S_R_EXEC;
        else if (Opcode == OP_BEQ || Opcode == OP_BNE)       state_nxt = S_BRANCH;
        else if (Opcode == OP_J)                             state_nxt = S_JUMP;
        else if (Opcode == OP_LI)                            state_nxt = S_LI_ADDR;
        else if (Opcode inside {6'b110010, 6'b110011, 6'b110111}) state_nxt = S_I_EXEC_SE;
        else if (Opcode inside {6'b110100, 6'b110101})       state_nxt = S_I_EXEC_ZE;
        else if (Opcode == OP_NOOP)                          state_nxt = S_FETCH;
        else begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b01;
        end
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b11; ALUOp = ALU_ADD;
        state_nxt = (Opcode == OP_LWI) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1; MemtoReg = 1'b1; state_nxt = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_R_EXEC: begin
        ALUSrcA = 2'b01; ReadDst = 1'b1; ALUOp = op_alu; state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        ALUSrcA = 2'b01; RegWrite = 1'b1; ReadDst = !imm_wb; state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b01; PCWriteCond = 2'b01; PCSource = 2'b01;
        BranchSel = (Opcode == OP_BNE); state_nxt = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1; PCSource = 2'b10; ReadDst = 1'b1; state_nxt = S_FETCH;
      end
      S_LI_ADDR: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b11; state_nxt = S_LI_RD;
      end
      S_LI_RD: begin
        MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = mem_ready;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_I_EXEC_SE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUOp = op_alu; state_nxt = S_ALU_WB;
      end
      S_I_EXEC_ZE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b11; ALUOp = op_alu; state_nxt = S_ALU_WB;
      end
      S_TRAP: begin
        Trap = 1'b1; PCWrite = 1'b1; PCSource = 2'b11; state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    if (tmo) begin
      state_nxt = S_TRAP;
      cause_nxt = 2'b10;
    end
    // While held in reset the bus must show the idle pattern, not the FETCH decode.
    if (!Reset) begin
      ALUSrcA = 2'b00; ALUSrcB = 2'b01; ALUOp = '0; PCSource = 2'b00; PCWrite = 1'b0;
      PCWriteCond = 2'b00; BranchSel = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
      ReadDst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; Trap = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      InstrCount <= '0;
      StallCount <= '0;
    end else begin
      if (state == S_FETCH && mem_ready) InstrCount <= InstrCount + CNT_W'(1);
      if (Busy)                          StallCount <= StallCount + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Bench for multicycle_ctrl_hs: per-instruction state paths with random memory waits,
// checked cycle by cycle against an expected-path model.
module tb_multicycle_ctrl_hs;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic [3:0] State;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource, PCWriteCond, TrapCause;
  logic [2:0] ALUOp;
  logic       PCWrite, BranchSel, RegWrite, MemtoReg, ReadDst, MemRead, MemWrite, IRWrite, Trap, Busy;
`ifdef PERF_CNT_EN
  logic [31:0] InstrCount, StallCount;
  int          icnt, scnt;
`endif

  multicycle_ctrl_hs #(.ALUOP_W(3), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .Reset(Reset), .Opcode(Opcode), .mem_ready(mem_ready), .State(State),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchSel(BranchSel),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ReadDst(ReadDst), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .Trap(Trap), .TrapCause(TrapCause),
`ifdef PERF_CNT_EN
    .InstrCount(InstrCount), .StallCount(StallCount),
`endif
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [3:0] prev;
    logic [1:0] cause;
  } step_t;

  step_t      plan[$];
  logic [1:0] mcause = 2'b00;
  logic [3:0] mprev  = 4'd0;
  bit         dead;
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [20:0] dut_ctl;
  assign dut_ctl = {ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond, BranchSel,
                    RegWrite, MemtoReg, ReadDst, MemRead, MemWrite, IRWrite, Trap, Busy};
  // Idle pattern: only ALUSrcB=01 and ReadDst=1.
  localparam logic [20:0] RST_CTL = {2'b00, 2'b01, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0,
                                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mem_st(input logic [3:0] s);
    return s inside {4'd0, 4'd3, 4'd5, 4'd11};
  endfunction

  function automatic bit rtype(input logic [5:0] op);
    return op inside {[6'b010000:6'b010101], 6'b010111};
  endfunction

  // Expected control bus for one cycle, straight from the per-state output table.
  function automatic logic [20:0] exp_ctl(input step_t e, input logic [5:0] op);
    logic [1:0] a, b, ps, pwc;
    logic [2:0] alu;
    logic pw, bs, rw, m2r, rd, mr, mw, ir, tr, bz;
    a = 0; b = 0; ps = 0; pwc = 0; alu = 0;
    pw = 0; bs = 0; rw = 0; m2r = 0; rd = 0; mr = 0; mw = 0; ir = 0; tr = 0;
    bz = mem_st(e.st) && !e.rdy;
    case (e.st)
      4'd0:  begin mr = 1; b = 1; alu = 3'b010; rd = 1; ir = e.rdy; pw = e.rdy; end
      4'd1:  begin b = 2; alu = 3'b010; rd = rtype(op); end
      4'd2:  begin a = 1; b = 3; alu = 3'b010; end
      4'd3:  mr = 1;
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  mw = 1;
      4'd6:  begin a = 1; rd = 1; alu = op[2:0]; end
      4'd7:  begin a = 1; rw = 1; rd = (e.prev == 4'd6); end
      4'd8:  begin a = 1; pwc = 1; ps = 1; bs = (op == 6'b100001); end
      4'd9:  begin pw = 1; ps = 2; rd = 1; end
      4'd10: begin a = 1; b = 3; end
      4'd11: begin mr = 1; m2r = 1; rw = e.rdy; end
      4'd12: begin a = 1; b = 2; alu = op[2:0]; end
      4'd13: begin a = 1; b = 3; alu = op[2:0]; end
      4'd14: begin tr = 1; pw = 1; ps = 3; end
      default: ;
    endcase
    return {a, b, alu, ps, pw, pwc, bs, rw, m2r, rd, mr, mw, ir, tr, bz};
  endfunction

  task automatic push(input logic [3:0] s, input logic r);
    step_t e;
    e.st = s; e.rdy = r; e.prev = mprev; e.cause = mcause;
    plan.push_back(e);
    mprev = s;
  endtask

  // A memory state stalls w cycles then completes, or traps once the stall hits TMO cycles.
  task automatic visit(input logic [3:0] s, input int w);
    if (dead) return;
    if (mem_st(s)) begin
      if (w >= TMO) begin
        repeat (TMO) push(s, 1'b0);
        mcause = 2'b10;
        push(4'd14, 1'($urandom));
        dead = 1;
      end else begin
        repeat (w) push(s, 1'b0);
        push(s, 1'b1);
      end
    end else push(s, 1'($urandom));
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int abort_st);
    plan.delete();
    dead = 0;
    visit(4'd0, wf);
    visit(4'd1, 0);
    if (op == 6'b111011) begin visit(4'd2, 0); visit(4'd3, wm); visit(4'd4, 0); end
    else if (op == 6'b111100) begin visit(4'd2, 0); visit(4'd5, wm); end
    else if (rtype(op)) begin visit(4'd6, 0); visit(4'd7, 0); end
    else if (op inside {6'b100000, 6'b100001}) visit(4'd8, 0);
    else if (op == 6'b000001) visit(4'd9, 0);
    else if (op == 6'b111001) begin visit(4'd10, 0); visit(4'd11, wm); end
    else if (op inside {6'b110010, 6'b110011, 6'b110111}) begin visit(4'd12, 0); visit(4'd7, 0); end
    else if (op inside {6'b110100, 6'b110101}) begin visit(4'd13, 0); visit(4'd7, 0); end
    else if (op != 6'b000000 && !dead) begin mcause = 2'b01; push(4'd14, 1'($urandom)); end
    foreach (plan[i]) begin
      Opcode = op;
      mem_ready = plan[i].rdy;
      #1;
      chk($sformatf("state op=%b step=%0d", op, i), 32'(State), 32'(plan[i].st));
      chk($sformatf("ctl op=%b st=%0d", op, plan[i].st), 32'(dut_ctl), 32'(exp_ctl(plan[i], op)));
      chk($sformatf("cause op=%b st=%0d", op, plan[i].st), 32'(TrapCause), 32'(plan[i].cause));
`ifdef PERF_CNT_EN
      if (plan[i].st == 4'd0 && plan[i].rdy) icnt++;
      if (mem_st(plan[i].st) && !plan[i].rdy) scnt++;
`endif
      if (abort_st >= 0 && int'(plan[i].st) == abort_st && !plan[i].rdy) begin
        #2 Reset = 1'b0;
        #1;
        mcause = 2'b00;
        chk("async_rst state", 32'(State), 32'd0);
        chk("async_rst ctl", 32'(dut_ctl), 32'(RST_CTL));
        chk("async_rst cause", 32'(TrapCause), 32'd0);
`ifdef PERF_CNT_EN
        icnt = 0; scnt = 0;
        chk("async_rst icnt", InstrCount, 32'd0);
        chk("async_rst scnt", StallCount, 32'd0);
`endif
        return;
      end
      @(negedge clk);
    end
  endtask

  logic [5:0] legal[16] = '{6'b111011, 6'b111100, 6'b010000, 6'b010101, 6'b010111, 6'b010010,
                            6'b100000, 6'b100001, 6'b000001, 6'b111001, 6'b110010, 6'b110011,
                            6'b110111, 6'b110100, 6'b110101, 6'b000000};

  initial begin
    Reset = 1'b0; Opcode = 6'd0; mem_ready = 1'b0;
`ifdef PERF_CNT_EN
    icnt = 0; scnt = 0;
`endif
    repeat (2) @(negedge clk);
    chk("reset state", 32'(State), 32'd0);
    chk("reset ctl", 32'(dut_ctl), 32'(RST_CTL));
    chk("reset cause", 32'(TrapCause), 32'd0);
    Reset = 1'b1;

    run_instr(6'b010010, 0, 0, -1);  // R-type add
    run_instr(6'b111011, 0, 3, -1);  // LWI, completes on the timeout cycle
    run_instr(6'b010110, 1, 0, -1);  // hole in R-type range -> illegal trap
    run_instr(6'b111100, 0, 9, -1);  // SWI, memory stuck -> timeout trap
    run_instr(6'b100001, 0, 0, -1);  // BNE
    run_instr(6'b100000, 2, 0, -1);  // BEQ
    run_instr(6'b000001, 0, 0, -1);  // J
    run_instr(6'b111001, 0, 2, -1);  // LI
    run_instr(6'b110010, 0, 0, -1);  // SE
    run_instr(6'b110101, 0, 0, -1);  // ZE
    run_instr(6'b000000, 0, 0, -1);  // NOOP
    run_instr(6'b111001, 5, 0, -1);  // timeout in FETCH
    run_instr(6'b111100, 0, 3, 5);   // reset asserted while stalled in MEM_WR
    @(negedge clk);
    Reset = 1'b1;

    for (int n = 0; n < 120; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 15)];
      run_instr(op, $urandom_range(0, 5), $urandom_range(0, 5), -1);
    end
`ifdef PERF_CNT_EN
    chk("icnt", InstrCount, 32'(icnt));
    chk("scnt", StallCount, 32'(scnt));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
